// File: rtl/req_merge_buffer_mp.sv
// Multi-port request merge buffer: merges same-address requests onto one entry, issues each entry once round-robin, frees on last release.
// req_ready is same-cycle (registered state only); alloc->issue_valid >= 1 cycle; a refused port holds its request and retries.
module req_merge_buffer_mp #(
  parameter int ENTRY_NUM = 32,
  parameter int PORT_NUM  = 4,
  parameter int ADDR_W    = 32,
  parameter int REFCNT_W  = 6,
  parameter int ENTRY_W   = $clog2(ENTRY_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORT_NUM-1:0]          req_valid,
  input  logic [PORT_NUM*ADDR_W-1:0]   req_addr,
  output logic [PORT_NUM-1:0]          req_ready,
  output logic [PORT_NUM*ENTRY_W-1:0]  req_entry,
  output logic                         issue_valid,
  output logic [ADDR_W-1:0]            issue_addr,
  output logic [ENTRY_W-1:0]           issue_entry,
  input  logic                         issue_ready,
  input  logic                         release_valid,
  input  logic [ENTRY_W-1:0]           release_entry,
  output logic [ENTRY_W:0]             occupancy,
  output logic                         err_release
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ISSUED = 2'd2
  } st_e;

  localparam logic [REFCNT_W-1:0] REF_MAX  = '1;
  localparam logic [REFCNT_W-1:0] REF_ONE  = REFCNT_W'(1);
  localparam logic [REFCNT_W-1:0] REF_ZERO = '0;
  localparam logic [ENTRY_W:0]    OCC_ONE  = (ENTRY_W+1)'(1);

  st_e                 st_q   [ENTRY_NUM];
  st_e                 st_d   [ENTRY_NUM];
  logic [REFCNT_W-1:0] ref_q  [ENTRY_NUM];
  logic [REFCNT_W-1:0] ref_d  [ENTRY_NUM];
  logic [ADDR_W-1:0]   addr_q [ENTRY_NUM];
  logic [ADDR_W-1:0]   addr_d [ENTRY_NUM];
  logic [ENTRY_W-1:0]  rr_q, rr_d;
  logic [ENTRY_W:0]    occ_q, occ_d;
  logic                err_q, err_d;

  logic [ENTRY_NUM-1:0] alloc_vec;
  logic [ADDR_W-1:0]    alloc_addr [ENTRY_NUM];
  logic [REFCNT_W-1:0]  grp_cnt    [ENTRY_NUM];
  logic                 issue_fire;
  logic                 rel_ok;

  // Ports are resolved in index order; grp_cnt tracks the reference total each entry would hold after this cycle's claims.
  always_comb begin : accept_logic
    logic               hit_found;
    logic               free_found;
    logic [ENTRY_W-1:0] hit_idx;
    logic [ENTRY_W-1:0] free_idx;
    logic [ADDR_W-1:0]  p_addr;
    logic [ADDR_W-1:0]  e_addr;
    req_ready  = '0;
    req_entry  = '0;
    alloc_vec  = '0;
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    p_addr     = '0;
    e_addr     = '0;
    for (int e = 0; e < ENTRY_NUM; e++) begin
      alloc_addr[e] = '0;
      grp_cnt[e]    = ref_q[e];
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      p_addr     = req_addr[p*ADDR_W +: ADDR_W];
      hit_found  = 1'b0;
      free_found = 1'b0;
      hit_idx    = '0;
      free_idx   = '0;
      for (int e = 0; e < ENTRY_NUM; e++) begin
        e_addr = alloc_vec[e] ? alloc_addr[e] : addr_q[e];
        if (!hit_found && (st_q[e] != ST_FREE || alloc_vec[e]) && e_addr == p_addr) begin
          hit_found = 1'b1;
          hit_idx   = ENTRY_W'(e);
        end
        if (!free_found && st_q[e] == ST_FREE && !alloc_vec[e]) begin
          free_found = 1'b1;
          free_idx   = ENTRY_W'(e);
        end
      end
      if (req_valid[p]) begin
        // A saturated hit is refused rather than spilled to a second entry, so an address never lives twice.
        if (hit_found) begin
          if (grp_cnt[hit_idx] != REF_MAX) begin
            req_ready[p]                        = 1'b1;
            req_entry[p*ENTRY_W +: ENTRY_W]     = hit_idx;
            grp_cnt[hit_idx]                    = grp_cnt[hit_idx] + REF_ONE;
          end
        end else if (free_found) begin
          alloc_vec[free_idx]                   = 1'b1;
          alloc_addr[free_idx]                  = p_addr;
          grp_cnt[free_idx]                     = REF_ONE;
          req_ready[p]                          = 1'b1;
          req_entry[p*ENTRY_W +: ENTRY_W]       = free_idx;
        end
      end
    end
  end

  always_comb begin : issue_pick
    logic [ENTRY_W-1:0] idx;
    issue_valid = 1'b0;
    issue_entry = rr_q;
    idx         = rr_q;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      idx = rr_q + ENTRY_W'(i);
      if (!issue_valid && st_q[idx] == ST_PEND) begin
        issue_valid = 1'b1;
        issue_entry = idx;
      end
    end
  end

  assign issue_addr = addr_q[issue_entry];
  assign issue_fire = issue_valid & issue_ready;
  assign rel_ok     = release_valid && (st_q[release_entry] == ST_ISSUED);

  always_comb begin : next_state
    logic [REFCNT_W-1:0] nref;
    rr_d  = issue_fire ? issue_entry + ENTRY_W'(1) : rr_q;
    err_d = release_valid && !rel_ok;
    occ_d = occ_q;
    nref  = '0;
    for (int e = 0; e < ENTRY_NUM; e++) begin
      st_d[e]   = st_q[e];
      ref_d[e]  = ref_q[e];
      addr_d[e] = addr_q[e];
      if (alloc_vec[e]) begin
        st_d[e]   = ST_PEND;
        addr_d[e] = alloc_addr[e];
        ref_d[e]  = grp_cnt[e];
        occ_d     = occ_d + OCC_ONE;
      end else if (st_q[e] != ST_FREE) begin
        // Merges and a release on the same entry net out; a merge can keep a last-released entry alive.
        nref = grp_cnt[e] - ((rel_ok && release_entry == ENTRY_W'(e)) ? REF_ONE : REF_ZERO);
        ref_d[e] = nref;
        if (issue_fire && issue_entry == ENTRY_W'(e)) begin
          st_d[e] = ST_ISSUED;
        end
        if (nref == REF_ZERO) begin
          st_d[e] = ST_FREE;
          occ_d   = occ_d - OCC_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ENTRY_NUM; e++) begin
        st_q[e]   <= ST_FREE;
        ref_q[e]  <= '0;
        addr_q[e] <= '0;
      end
      rr_q  <= '0;
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int e = 0; e < ENTRY_NUM; e++) begin
        st_q[e]   <= st_d[e];
        ref_q[e]  <= ref_d[e];
        addr_q[e] <= addr_d[e];
      end
      rr_q  <= rr_d;
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  assign occupancy   = occ_q;
  assign err_release = err_q;

endmodule

// File: tb/tb_req_merge_buffer_mp.sv
// Bench for req_merge_buffer_mp: vector table, directed corner sequences and random traffic against a reference model.
module tb_req_merge_buffer_mp;
  localparam int EN = 32, PN = 4, AW = 32, EW = 5, MAXR = 63;

  logic clk = 1'b0;
  logic rst;
  logic [PN-1:0]    rv;
  logic [AW-1:0]    ra [PN];
  logic [PN*AW-1:0] ra_flat;
  logic             ir, relv;
  logic [EW-1:0]    rele;

  logic [PN-1:0]    rdy;
  logic [PN*EW-1:0] ent;
  logic             iv;
  logic [AW-1:0]    ia;
  logic [EW-1:0]    ie;
  logic [EW:0]      occ;
  logic             err;

  logic [3:0]  rdy2;
  logic [7:0]  ent2;
  logic        iv2;
  logic [31:0] ia2;
  logic [1:0]  ie2;
  logic [2:0]  occ2;
  logic        err2;

  assign ra_flat = {ra[3], ra[2], ra[1], ra[0]};
  always #5 clk = ~clk;

  req_merge_buffer_mp dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_addr(ra_flat), .req_ready(rdy), .req_entry(ent),
    .issue_valid(iv), .issue_addr(ia), .issue_entry(ie), .issue_ready(ir),
    .release_valid(relv), .release_entry(rele), .occupancy(occ), .err_release(err)
  );

  req_merge_buffer_mp #(.ENTRY_NUM(4), .PORT_NUM(4), .ADDR_W(32), .REFCNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(rv), .req_addr(ra_flat), .req_ready(rdy2), .req_entry(ent2),
    .issue_valid(iv2), .issue_addr(ia2), .issue_entry(ie2), .issue_ready(ir),
    .release_valid(relv), .release_entry(rele[1:0]), .occupancy(occ2), .err_release(err2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: entry state 0=free 1=pending 2=issued.
  int          m_st  [EN];
  int          m_ref [EN];
  logic [31:0] m_addr[EN];
  int          m_rr;
  bit          m_err;
  bit          m_new [EN];
  logic [31:0] m_na  [EN];
  int          m_tot [EN];
  logic [3:0]  x_rdy;
  logic [19:0] x_ent;
  bit          x_iv;
  int          x_ie;

  task automatic model_reset();
    for (int e = 0; e < EN; e++) begin
      m_st[e] = 0; m_ref[e] = 0; m_addr[e] = '0;
    end
    m_rr = 0; m_err = 0;
  endtask

  task automatic model_eval();
    int hit, fr;
    x_rdy = '0; x_ent = '0;
    for (int e = 0; e < EN; e++) begin
      m_tot[e] = m_ref[e]; m_new[e] = 0; m_na[e] = '0;
    end
    for (int p = 0; p < PN; p++) begin
      if (rv[p]) begin
        hit = -1; fr = -1;
        for (int e = 0; e < EN; e++)
          if (hit < 0 && (m_st[e] != 0 || m_new[e]) && (m_new[e] ? m_na[e] : m_addr[e]) == ra[p]) hit = e;
        if (hit >= 0) begin
          if (m_tot[hit] < MAXR) begin
            x_rdy[p] = 1'b1; x_ent[p*EW +: EW] = 5'(hit); m_tot[hit]++;
          end
        end else begin
          for (int e = 0; e < EN; e++)
            if (fr < 0 && m_st[e] == 0 && !m_new[e]) fr = e;
          if (fr >= 0) begin
            m_new[fr] = 1; m_na[fr] = ra[p]; m_tot[fr] = 1;
            x_rdy[p] = 1'b1; x_ent[p*EW +: EW] = 5'(fr);
          end
        end
      end
    end
    x_iv = 0; x_ie = 0;
    for (int i = 0; i < EN; i++)
      if (!x_iv && m_st[(m_rr + i) % EN] == 1) begin
        x_iv = 1; x_ie = (m_rr + i) % EN;
      end
  endtask

  task automatic model_commit();
    bit fire, rok;
    fire = x_iv && ir;
    rok  = relv && (m_st[rele] == 2);
    for (int e = 0; e < EN; e++) begin
      if (m_new[e]) begin
        m_st[e] = 1; m_addr[e] = m_na[e]; m_ref[e] = m_tot[e];
      end else if (m_st[e] != 0) begin
        m_ref[e] = m_tot[e] - ((rok && int'(rele) == e) ? 1 : 0);
        if (fire && x_ie == e) m_st[e] = 2;
        if (m_ref[e] == 0) m_st[e] = 0;
      end
    end
    m_err = relv && !rok;
    if (fire) m_rr = (x_ie + 1) % EN;
  endtask

  // Called at the negative edge: compare against the model, advance it, move to just after the next posedge.
  task automatic step();
    logic [37:0] act_i, exp_i;
    int cnt;
    model_eval();
    cnt = 0;
    for (int e = 0; e < EN; e++) if (m_st[e] != 0) cnt++;
    check("model_req", {rdy, ent}, {x_rdy, x_ent});
    act_i = {iv, iv ? ie : 5'd0, iv ? ia : 32'd0};
    exp_i = {x_iv, x_iv ? 5'(x_ie) : 5'd0, x_iv ? m_addr[x_ie] : 32'd0};
    check("model_issue", act_i, exp_i);
    check("model_occ_err", {occ, err}, {6'(cnt), m_err});
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; rv = '0; ir = 1'b0; relv = 1'b0; rele = '0;
    for (int p = 0; p < PN; p++) ra[p] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int rv; int a0; int a1; int a2; int a3;
    int ir; int relv; int rele;
    int rdy; int ent; int iv; int ie; int ia; int occ; int err;
  } vec_t;

  vec_t tbl[18];
  int   rr_order[3];

  initial begin
    //           rv   a0     a1     a2     a3    ir relv rele  rdy  ent iv ie  ia    occ err
    tbl[0]  = '{'hF, 'h100, 'h100, 'h100, 'h100, 0, 0, 0,   'hF, 0,  0, 0, 0,     0, 0};
    tbl[1]  = '{0,   0,     0,     0,     0,     1, 0, 0,   0,   0,  1, 0, 'h100, 1, 0};
    tbl[2]  = '{0,   0,     0,     0,     0,     0, 1, 0,   0,   0,  0, 0, 0,     1, 0};
    tbl[3]  = '{0,   0,     0,     0,     0,     0, 1, 0,   0,   0,  0, 0, 0,     1, 0};
    tbl[4]  = '{0,   0,     0,     0,     0,     0, 1, 0,   0,   0,  0, 0, 0,     1, 0};
    tbl[5]  = '{0,   0,     0,     0,     0,     0, 1, 0,   0,   0,  0, 0, 0,     1, 0};
    tbl[6]  = '{0,   0,     0,     0,     0,     0, 1, 0,   0,   0,  0, 0, 0,     0, 0};
    tbl[7]  = '{0,   0,     0,     0,     0,     0, 0, 0,   0,   0,  0, 0, 0,     0, 1};
    tbl[8]  = '{1,   'h200, 0,     0,     0,     0, 0, 0,   1,   0,  0, 0, 0,     0, 0};
    tbl[9]  = '{2,   0,     'h200, 0,     0,     1, 0, 0,   2,   0,  1, 0, 'h200, 1, 0};
    tbl[10] = '{7,   'h300, 'h300, 'h200, 0,     0, 1, 0,   7,   33, 0, 0, 0,     1, 0};
    tbl[11] = '{0,   0,     0,     0,     0,     1, 1, 0,   0,   0,  1, 1, 'h300, 2, 0};
    tbl[12] = '{8,   0,     0,     0,     'h200, 0, 1, 0,   8,   0,  0, 0, 0,     2, 0};
    tbl[13] = '{0,   0,     0,     0,     0,     0, 1, 0,   0,   0,  0, 0, 0,     2, 0};
    tbl[14] = '{0,   0,     0,     0,     0,     0, 0, 0,   0,   0,  0, 0, 0,     1, 0};
    tbl[15] = '{3,   'h300, 'h400, 0,     0,     0, 0, 0,   3,   1,  0, 0, 0,     1, 0};
    tbl[16] = '{0,   0,     0,     0,     0,     0, 1, 0,   0,   0,  1, 0, 'h400, 2, 0};
    tbl[17] = '{0,   0,     0,     0,     0,     0, 0, 0,   0,   0,  1, 0, 'h400, 2, 1};
    rr_order = '{7, 2, 5};

    do_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("reset_occ", occ, 0);
      check("reset_iv", iv, 0);
      check("reset_rdy", rdy, 0);
      check("reset_err", err, 0);
      step();
    end

    // Merge, issue, release, rescue and error cases.
    foreach (tbl[i]) begin
      rv = 4'(tbl[i].rv);
      ra[0] = 32'(tbl[i].a0); ra[1] = 32'(tbl[i].a1); ra[2] = 32'(tbl[i].a2); ra[3] = 32'(tbl[i].a3);
      ir = tbl[i].ir[0]; relv = tbl[i].relv[0]; rele = 5'(tbl[i].rele);
      settle();
      check($sformatf("vec%0d_rdy", i), rdy, 64'(tbl[i].rdy));
      check($sformatf("vec%0d_ent", i), ent, 64'(tbl[i].ent));
      check($sformatf("vec%0d_iv", i), iv, 64'(tbl[i].iv));
      if (tbl[i].iv != 0) begin
        check($sformatf("vec%0d_ie", i), ie, 64'(tbl[i].ie));
        check($sformatf("vec%0d_ia", i), ia, 64'(tbl[i].ia));
      end
      check($sformatf("vec%0d_occ", i), occ, 64'(tbl[i].occ));
      check($sformatf("vec%0d_err", i), err, 64'(tbl[i].err));
      step();
    end

    // Full buffer: a new address waits until a release frees an entry.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      rv = 4'hF;
      for (int p = 0; p < PN; p++) ra[p] = 32'h1000 + 32'((4*c + p) * 16);
      settle();
      check("fill_rdy", rdy, 4'hF);
      check("fill_ent", ent, {5'(4*c+3), 5'(4*c+2), 5'(4*c+1), 5'(4*c)});
      step();
    end
    rv = 4'h1; ra[0] = 32'h9000; ra[1] = '0; ra[2] = '0; ra[3] = '0; ir = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("full_occ", occ, 32);
      check("full_rdy", rdy, 0);
      check("full_issue", {iv, ie}, {1'b1, 5'(k)});
      step();
    end
    ir = 1'b0; relv = 1'b1; rele = 5'd3;
    settle();
    check("full_rel_rdy", rdy, 0);
    step();
    relv = 1'b0;
    settle();
    check("full_alloc_rdy", rdy, 1);
    check("full_alloc_ent", ent[4:0], 3);
    check("full_alloc_occ", occ, 31);
    step();
    rv = '0;
    settle();
    check("full_after_occ", occ, 32);
    step();

    // Round-robin wrap: entries 2,5,7 pending with rr at 6.
    do_reset();
    rv = 4'hF; ra[0] = 32'h2000; ra[1] = 32'h2010; ra[2] = 32'h2020; ra[3] = 32'h2030;
    cyc();
    rv = 4'h7; ra[0] = 32'h2040; ra[1] = 32'h2050; ra[2] = 32'h2060; ra[3] = '0;
    cyc();
    rv = '0; ir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      settle();
      check("rr_warm", {iv, ie}, {1'b1, 5'(i)});
      step();
    end
    ir = 1'b0; relv = 1'b1; rele = 5'd5;
    cyc();
    relv = 1'b0; rv = 4'h1; ra[0] = 32'h3000;
    settle();
    check("rr_realloc", ent[4:0], 5);
    step();
    rv = '0; ir = 1'b1;
    settle();
    check("rr_issue5", {iv, ie}, {1'b1, 5'd5});
    step();
    ir = 1'b0; relv = 1'b1; rele = 5'd2;
    cyc();
    rele = 5'd5;
    cyc();
    relv = 1'b0; rv = 4'h7; ra[0] = 32'h4000; ra[1] = 32'h4010; ra[2] = 32'h4020;
    settle();
    check("rr_alloc3", ent[14:0], {5'd7, 5'd5, 5'd2});
    step();
    rv = '0; ir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rr_order", {iv, ie}, {1'b1, 5'(rr_order[i])});
      step();
    end
    settle();
    check("rr_drained", iv, 0);
    step();
    ir = 1'b0;

    // Saturation on the 2-bit refcount instance (max 3 references).
    do_reset();
    rv = 4'h7; ra[0] = 32'h500; ra[1] = 32'h500; ra[2] = 32'h500;
    settle();
    check("sat_first_rdy", rdy2, 4'h7);
    check("sat_first_ent", ent2, 0);
    step();
    rv = 4'h3; ir = 1'b1;
    settle();
    check("sat_full_rdy", rdy2, 0);
    check("sat_issue", {iv2, ie2, ia2}, {1'b1, 2'd0, 32'h500});
    step();
    ir = 1'b0; relv = 1'b1; rele = 5'd0;
    settle();
    check("sat_prerelease_rdy", rdy2, 0);
    step();
    relv = 1'b0;
    settle();
    check("sat_retry_rdy", rdy2, 4'h1);
    check("sat_retry_ent", ent2, 0);
    check("sat_retry_occ", occ2, 1);
    step();
    rv = 4'h2; relv = 1'b1;
    settle();
    check("sat_hold_rdy", rdy2, 0);
    step();
    relv = 1'b0;
    settle();
    check("sat_last_rdy", rdy2, 4'h2);
    check("sat_last_ent", ent2, 0);
    check("sat_err", err2, 0);
    step();
    rv = '0;
    settle();
    check("sat_occ", occ2, 1);
    step();

    // Random traffic: sparse phases let entries drain, dense phases fill and saturate.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      int iss[$];
      iss.delete();
      if (((i / 250) % 2) == 1) rv = 4'($urandom_range(15));
      else rv = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0;
      for (int p = 0; p < PN; p++) ra[p] = 32'h8000 + 32'($urandom_range(39) * 4);
      ir = ($urandom_range(3) != 0);
      for (int e = 0; e < EN; e++) if (m_st[e] == 2) iss.push_back(e);
      relv = ($urandom_range(9) != 0);
      if (iss.size() > 0 && $urandom_range(7) != 0) rele = 5'(iss[$urandom_range(iss.size() - 1)]);
      else rele = 5'($urandom_range(EN - 1));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
